// File: rtl/div_ctrl.sv
// Multi-cycle 32-bit restoring divider: result = {remainder, quotient}, 35 cycles accept-to-done.
// Define DIV_SIGNED_EN for two's-complement operands; the default build divides unsigned.
module div_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [63:0] result,
    output logic        div_zero
);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] mag_b;
    logic [31:0] quo;
    logic [32:0] rem;
    logic [4:0]  count;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a_init;
    logic [31:0] mag_b_init;
    logic [32:0] rem_shift;
    logic [33:0] diff;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = PREP;
            PREP: begin
                busy       = 1'b1;
                state_next = (op_b == 32'd0) ? DONE : ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (count == 5'd31) state_next = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Sign handling collapses to pass-through when the signed feature is off.
    always_comb begin
`ifdef DIV_SIGNED_EN
        a_neg = op_a[31];
        b_neg = op_b[31];
`else
        a_neg = 1'b0;
        b_neg = 1'b0;
`endif
        mag_a_init = a_neg ? -op_a : op_a;
        mag_b_init = b_neg ? -op_b : op_b;
        quo_fix    = (a_neg ^ b_neg) ? -quo : quo;
        rem_fix    = a_neg ? -rem[31:0] : rem[31:0];
    end

    // quo doubles as the dividend shift register: dividend bits leave at the top,
    // quotient bits enter at the bottom.
    always_comb begin
        rem_shift = {rem[31:0], quo[31]};
        diff      = {1'b0, rem_shift} - {2'b00, mag_b};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_a     <= 32'd0;
            op_b     <= 32'd0;
            mag_b    <= 32'd0;
            quo      <= 32'd0;
            rem      <= 33'd0;
            count    <= 5'd0;
            result   <= 64'd0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a     <= dividend;
                        op_b     <= divisor;
                        div_zero <= 1'b0;
                    end
                end
                PREP: begin
                    quo   <= mag_a_init;
                    mag_b <= mag_b_init;
                    rem   <= 33'd0;
                    count <= 5'd0;
                    if (op_b == 32'd0) begin
                        result   <= {op_a, 32'hFFFF_FFFF};
                        div_zero <= 1'b1;
                    end
                end
                ITER: begin
                    quo   <= {quo[30:0], ~diff[33]};
                    rem   <= diff[33] ? rem_shift : diff[32:0];
                    count <= count + 5'd1;
                end
                FIX: result <= {rem_fix, quo_fix};
                default: ;
            endcase
        end
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  request a division; sampled only in IDLE.
REQ-004 SHALL have port: dividend  input  32  operand A; captured on accepted start.
REQ-005 SHALL have port: divisor  input  32  operand B; captured on accepted start.
REQ-006 SHALL have port: busy  output  1  high from the cycle after acceptance until done.
REQ-007 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-008 SHALL have port: result  output  64  {remainder[63:32], quotient[31:0]}; held until the next accepted start.
REQ-009 SHALL have port: div_zero  output  1  set with done when the captured divisor was 0; held with result.

Function
REQ-010 SHALL implement FSM states IDLE, PREP, ITER, FIX, DONE.
REQ-011 SHALL accept start only in IDLE; start while busy SHALL be ignored, with no queueing.
REQ-012 SHALL on accept (cycle N) latch operands, clear div_zero, and enter PREP at N+1.
REQ-013 SHALL in PREP form operand magnitudes (see Configuration), zero the 33-bit partial remainder and the 5-bit step counter, and enter ITER; if divisor==0, SHALL enter DONE directly.
REQ-014 SHALL in ITER perform one restoring step per cycle, MSB first: shift {rem,dividend bit}, subtract the divisor magnitude, set the quotient bit = ~sign(difference), and keep the difference only when non-negative.
REQ-015 SHALL spend exactly 32 cycles in ITER (N+2..N+33), counter wrap 31->0 exiting to FIX.
REQ-016 SHALL in FIX (N+34) apply sign correction and load result, entering DONE.
REQ-017 SHALL pulse done for exactly one cycle in DONE (N+35) with busy low, returning to IDLE at N+36; total latency 35 cycles from accept to done.
REQ-018 SHALL on divide-by-zero assert done at N+2 with result = {dividend, 32'hFFFFFFFF} and div_zero=1.
REQ-019 SHALL satisfy dividend == quotient*divisor + remainder (mod 2^32), with |remainder| < |divisor| for every nonzero divisor.
REQ-020 SHALL produce, in signed mode, 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0 (wrap, no flag).
REQ-021 SHALL keep busy high in PREP, ITER and FIX, and low in IDLE and DONE.

Reset
REQ-022 SHALL on reset high at any clock edge, including mid-ITER, force IDLE, busy=0, done=0, div_zero=0, result=64'h0, and counter=0.
REQ-023 SHALL give reset priority over start in the same cycle; an operation interrupted by reset SHALL produce no done.

Configuration
REQ-024 SHALL, with macro DIV_SIGNED_EN defined, treat operands as two's complement: PREP negates negative operands; FIX negates the quotient when the operand signs differ and negates the remainder when the dividend is negative; divide-by-zero returns the remainder = raw dividend.
REQ-025 SHALL, without DIV_SIGNED_EN, treat operands as unsigned; PREP and FIX still occupy one cycle each, so latency is unchanged.

Verification
REQ-026 Unsigned/signed: 100 / 7 -> at N+35 done=1, result={32'd2, 32'd14}, div_zero=0.
REQ-027 DIV_SIGNED_EN: -100 / 7 -> quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2); and 0x80000000 / -1 -> {0, 0x80000000}.
REQ-028 Divisor 0, dividend 0x1234 -> done at N+2, result={0x00001234, 0xFFFFFFFF}, div_zero=1.
REQ-029 start held high for 40 cycles with 50/5 -> exactly one done at N+35 with {0, 10}; a second accept at N+36, and no acceptance while busy.
REQ-030 Reset asserted at N+10 during ITER -> the next cycle shows IDLE outputs all zero, no done pulse; a new start 9/3 then yields {0, 3} 35 cycles later.
REQ-031 Random 10k operand pairs compared against a reference model, including 0xFFFFFFFF/1, 1/0xFFFFFFFF and dividend<divisor cases.
